// File: rtl/input_debounce_4ch.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_4ch
// Brief    : Four independent input conditioners. Each channel is
//            synchronised, debounced with a consecutive-cycle counter, and
//            presented as a registered level plus a one-cycle rise pulse.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_4ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in1,
    input  logic raw_in2,
    input  logic raw_in3,
    input  logic raw_in4,
    output logic level1,
    output logic level2,
    output logic level3,
    output logic level4,
    output logic pulse1,
    output logic pulse2,
    output logic pulse3,
    output logic pulse4
);

    localparam int unsigned c_num_ch = 4;
    localparam int unsigned c_cnt_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    wire [c_num_ch-1:0] w_raw;
    wire [c_num_ch-1:0] w_level;
    wire [c_num_ch-1:0] w_pulse;

    assign w_raw = {raw_in4, raw_in3, raw_in2, raw_in1};

    for (genvar ch = 0; ch < c_num_ch; ch++) begin : g_ch
        logic               r_s1;
        logic               r_s2;
        logic               r_stable;
        logic               r_pulse;
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_differ;
        logic               w_accept;

        assign w_differ = r_s2 ^ r_stable;
        // The counter holds D-1 only when the disagreement has survived D edges.
        assign w_accept = w_differ && (r_cnt == c_cnt_max);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stable <= 1'b0;
                r_pulse  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1 <= w_raw[ch];
                r_s2 <= r_s1;

                if (!w_differ || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end

                if (w_accept) begin
                    r_stable <= r_s2;
                end

                // Only accepted 0->1 transitions pulse; falls update level silently.
                r_pulse <= w_accept & r_s2;
            end
        end

        assign w_level[ch] = r_stable;
        assign w_pulse[ch] = r_pulse;
    end

    assign level1 = w_level[0];
    assign level2 = w_level[1];
    assign level3 = w_level[2];
    assign level4 = w_level[3];
    assign pulse1 = w_pulse[0];
    assign pulse2 = w_pulse[1];
    assign pulse3 = w_pulse[2];
    assign pulse4 = w_pulse[3];

endmodule
`default_nettype wire
